// File: rtl/clk_freq_duty_meter.sv
// -----------------------------------------------------------------------------
// clk_freq_duty_meter
//   Measures the period and high time of sig_in in cycles of clk, then derives
//   the integer duty cycle in percent with a serial restoring divider.
//   sig_in is asynchronous to clk and is brought in through a 2-flop
//   synchronizer. The first (partial) period after reset or timeout is
//   discarded.
//
// Ports
//   clk           in   reference clock, all logic on posedge
//   rst           in   synchronous active-high reset
//   sig_in        in   measured signal (asynchronous)
//   period_cycles out  last measured period, clk cycles
//   high_cycles   out  last measured high time, clk cycles
//   duty_pct      out  floor(high_cycles*100/period_cycles)
//   meas_valid    out  1-cycle pulse, all three results updated
//   busy          out  divider running
//   overrun       out  1-cycle pulse, sample dropped because divider busy
//   timeout       out  sticky, no rising edge within 2**CNT_W-1 cycles
// -----------------------------------------------------------------------------
module clk_freq_duty_meter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_cycles,
   output logic [CNT_W-1:0] high_cycles,
   output logic [6:0]       duty_pct,
   output logic             meas_valid,
   output logic             busy,
   output logic             overrun,
   output logic             timeout
);

   // Rise-latch to meas_valid. The last divider iteration registers the
   // results directly, so the iteration count (= numerator width) is one less.
   localparam int DIV_LAT = CNT_W + 8;
   localparam int NW      = DIV_LAT - 1;
   localparam int IW      = $clog2(NW);

   typedef enum logic {ACQUIRE, MEASURE} state_t;

   state_t           state, state_nxt;
   logic             sync1, sig_s, sig_d, rise;
   logic [CNT_W-1:0] per_cnt, hi_cnt;
   logic             restart, sample, count, to_set;

   logic [CNT_W-1:0] lat_p, lat_h;
   logic [CNT_W-1:0] rem, rem_nxt;
   logic [NW-1:0]    num, num_nxt;
   logic [CNT_W:0]   shifted;
   logic             ge;
   logic [IW-1:0]    icnt;
   logic             div_last, div_idle, start;

   // Synchronizer is deliberately not reset: it keeps tracking sig_in during
   // reset, so a signal already high at reset release does not look like a rise.
   always_ff @(posedge clk) begin
      sync1 <= sig_in;
      sig_s <= sync1;
      sig_d <= sig_s;
   end

   assign rise = sig_s & ~sig_d;

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge clk) begin
      if (rst) state <= ACQUIRE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      restart   = 1'b0;
      sample    = 1'b0;
      count     = 1'b0;
      to_set    = 1'b0;
      case (state)
         ACQUIRE: begin
            if (rise) begin
               restart   = 1'b1;
               state_nxt = MEASURE;
            end
         end
         MEASURE: begin
            // A rise on the saturating cycle still yields a valid max period.
            if (rise) begin
               sample  = 1'b1;
               restart = 1'b1;
            end else if (per_cnt == '1) begin
               to_set    = 1'b1;
               state_nxt = ACQUIRE;
            end else begin
               count = 1'b1;
            end
         end
         default: state_nxt = ACQUIRE;
      endcase
   end

   // ----------------------------------------------------------- counters ---
   always_ff @(posedge clk) begin
      if (rst) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (restart) begin
         per_cnt <= CNT_W'(1);
         hi_cnt  <= CNT_W'(1);
      end else if (count) begin
         per_cnt <= per_cnt + CNT_W'(1);
         if (sig_s) hi_cnt <= hi_cnt + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------ divider ---
   // Restoring division of hi*100 by period, one quotient bit per cycle.
   // The divider counts as idle on its final cycle so a rise landing there
   // starts the next divide instead of being dropped.
   assign div_last = busy && (icnt == IW'(NW - 1));
   assign div_idle = !busy || div_last;
   assign start    = sample && div_idle;

   always_comb begin
      shifted = {rem, num[NW-1]};
      ge      = (shifted >= {1'b0, lat_p});
      rem_nxt = CNT_W'(ge ? (shifted - {1'b0, lat_p}) : shifted);
      num_nxt = {num[NW-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy          <= 1'b0;
         icnt          <= '0;
         rem           <= '0;
         num           <= '0;
         lat_p         <= '0;
         lat_h         <= '0;
         period_cycles <= '0;
         high_cycles   <= '0;
         duty_pct      <= '0;
         meas_valid    <= 1'b0;
         overrun       <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         meas_valid <= div_last;
         overrun    <= sample && !div_idle;

         if (busy) begin
            num  <= num_nxt;
            rem  <= rem_nxt;
            icnt <= icnt + IW'(1);
         end

         if (div_last) begin
            busy          <= 1'b0;
            period_cycles <= lat_p;
            high_cycles   <= lat_h;
            duty_pct      <= num_nxt[6:0];
         end

         // Placed after completion so a same-cycle start overrides the
         // divider registers while the outputs take the finished result.
         if (start) begin
            busy  <= 1'b1;
            lat_p <= per_cnt;
            lat_h <= hi_cnt;
            num   <= NW'(hi_cnt) * NW'(100);
            rem   <= '0;
            icnt  <= '0;
         end

         if (to_set)        timeout <= 1'b1;
         else if (div_last) timeout <= 1'b0;
      end
   end

endmodule
